vsr_univ_shift: RTL and testbench
=================================

# vsr_univ_shift

Parametrised universal shift register: a WIDTH-bit register supporting hold, bidirectional serial shift, parallel load, clear and optional rotate, selected per cycle by a 3-bit mode. It adds a registered serial-output stage on each end, a shift counter and a word-complete pulse for serialising or deserialising framed data. It sits in the register datapath as the general-purpose successor to the fixed 4-bit serial-in/serial-out register.

## Interface
- WIDTH, 4, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), shift-counter width; derived, not overridden.

- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately, release is synchronous to clk.
- en  input  1  operation enable; 0 forces hold regardless of mode.
- mode  input  3  operation select (see Operation).
- serial_in_r  input  1  bit entering MSB on shift right.
- serial_in_l  input  1  bit entering LSB on shift left.
- par_in  input  WIDTH  parallel load data.
- par_out  output  WIDTH  current register contents q.
- serial_out_r  output  1  registered copy of q[0].
- serial_out_l  output  1  registered copy of q[WIDTH-1].
- shift_cnt  output  CNT_W  shifts since last load/clear, saturating at WIDTH.
- word_done  output  1  one-cycle pulse when shift_cnt reaches WIDTH.

## Operation
- Reset (reset=0): q=0, serial_out_r=0, serial_out_l=0, shift_cnt=0, word_done=0.
- Mode decode, effective only when en=1 at the clk rising edge:
  - 000 hold: q unchanged.
  - 001 shift right: q <= {serial_in_r, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], serial_in_l}.
  - 011 parallel load: q <= par_in.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]} (macro-gated).
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]} (macro-gated).
  - 110 clear: q <= 0.
  - 111 reserved: behaves as hold.
- en=0: q, shift_cnt hold; word_done <= 0.
- Counter: every effective shift or rotate increments shift_cnt, saturating at WIDTH; load and clear set shift_cnt <= 0; hold/reserved leave it unchanged.
- word_done <= 1 on the edge where an effective shift/rotate moves shift_cnt from WIDTH-1 to WIDTH; 0 on every other edge. Saturated shifts (cnt already WIDTH) do not re-pulse.
- Serial outputs update every clock independent of en and mode: serial_out_r <= q[0], serial_out_l <= q[WIDTH-1] (pre-update q).

## Timing
- par_out reflects new q one clock after the sampling edge (register output, no combinational path from inputs).
- Serial latency, continuous shift right: bit on serial_in_r at edge N appears on serial_out_r after edge N+WIDTH (WIDTH+1 register stages total); symmetric for shift left to serial_out_l.
- serial_out_* lag par_out end bits by exactly one clock.
- word_done is asserted in the same cycle shift_cnt first reads WIDTH.
- Load and shift never coincide (single mode); load in the cycle after word_done restarts a frame with no lost cycle.
- Reset mid-operation: all outputs go to reset values asynchronously; first operation is sampled on the first rising edge with reset=1.

## Configuration
- VSR_ROTATE_EN defined: modes 100/101 rotate as above and count as shifts.
- Undefined: modes 100/101 behave as hold (q and shift_cnt unchanged, word_done <= 0); no rotate logic is synthesised.

## Test plan
- Reset: drive q via load 4'hA, pull reset low mid-cycle -> par_out=0, serial_out_r/l=0, shift_cnt=0, word_done=0 before next edge.
- WIDTH=4, load 4'b1011, mode 001 with serial_in_r=0 for 4 cycles -> serial_out_r sequence 1,1,0,1 on edges 2..5; word_done high only after edge 5 (shift_cnt=4), par_out=0.
- Shift left serial_in_l pattern 1,0,0,1 after clear -> par_out=4'b1001, word_done pulses once, further shifts keep shift_cnt=4 with no pulse.
- With VSR_ROTATE_EN, load 4'b0001, rotate right x4 -> par_out 1000,0100,0010,0001; without macro same stimulus -> par_out stays 0001, shift_cnt stays 0.
- en=0 with mode 001 for 3 cycles -> par_out, shift_cnt unchanged, word_done=0; mode 111 behaves identically.
- Load 4'hF at cycle shift_cnt=3, then clear -> shift_cnt=0 each time, no word_done.

Source files
------------

// File: rtl/vsr_univ_shift_if.sv
// Control and data bundle for the universal shift register; master drives controls, slave owns the outputs.
// All signals are sampled or updated on the rising edge of the clock the DUT is given.
interface vsr_univ_shift_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic             serial_in_r;
    logic             serial_in_l;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] par_out;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, serial_in_r, serial_in_l, par_in,
        input  par_out, serial_out_r, serial_out_l, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, serial_in_r, serial_in_l, par_in,
        output par_out, serial_out_r, serial_out_l, shift_cnt, word_done
    );
endinterface

// File: rtl/vsr_univ_shift.sv
// Universal shift register: hold/shift/load/clear per mode, shift counter, word-done pulse; VSR_ROTATE_EN adds rotate modes.
// Latency: par_out one clock after the sampling edge; serial_out_* one further clock behind the register end bits.
// Backpressure: none; en=0 stalls q and shift_cnt while the serial output stage keeps tracking q.
module vsr_univ_shift #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    vsr_univ_shift_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTR  = 3'b100,
        MODE_ROTL  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] cnt;
    logic             wd;
    logic             do_shift;
    logic             do_restart;

    always_comb begin
        q_nxt      = q;
        do_shift   = 1'b0;
        do_restart = 1'b0;
        if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_SHR: begin
                    q_nxt    = {bus.serial_in_r, q[WIDTH-1:1]};
                    do_shift = 1'b1;
                end
                MODE_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], bus.serial_in_l};
                    do_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt      = bus.par_in;
                    do_restart = 1'b1;
                end
`ifdef VSR_ROTATE_EN
                MODE_ROTR: begin
                    q_nxt    = {q[0], q[WIDTH-1:1]};
                    do_shift = 1'b1;
                end
                MODE_ROTL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    do_shift = 1'b1;
                end
`endif
                MODE_CLEAR: begin
                    q_nxt      = '0;
                    do_restart = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q      <= '0;
            sout_r <= 1'b0;
            sout_l <= 1'b0;
            cnt    <= '0;
            wd     <= 1'b0;
        end else begin
            q      <= q_nxt;
            // serial stage samples the pre-update register every clock
            sout_r <= q[0];
            sout_l <= q[WIDTH-1];
            wd     <= do_shift && (cnt == CNT_LAST);
            if (do_restart) begin
                cnt <= '0;
            end else if (do_shift && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.par_out      = q;
    assign bus.serial_out_r = sout_r;
    assign bus.serial_out_l = sout_l;
    assign bus.shift_cnt    = cnt;
    assign bus.word_done    = wd;
endmodule

// File: tb/tb_vsr_univ_shift.sv
// Scoreboard bench for vsr_univ_shift: directed frames plus random ops against an arithmetic reference model.
module tb_vsr_univ_shift;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

`ifdef VSR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]  q;
        logic          sr;
        logic          sl;
        logic [CW-1:0] cnt;
        logic          wd;
    } exp_t;

    logic clk;
    logic reset;
    vsr_univ_shift_if #(.WIDTH(W)) bus ();

    vsr_univ_shift #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    // reference state, plain integers
    int m_q, m_sr, m_sl, m_cnt, m_wd;
    int mask = (1 << W) - 1;

    task automatic model_reset();
        m_q = 0; m_sr = 0; m_sl = 0; m_cnt = 0; m_wd = 0;
    endtask

    task automatic model_step(input int en, input int mode, input int sir, input int sil, input int pin);
        bit shifted;
        shifted = 1'b0;
        m_sr = m_q & 1;
        m_sl = (m_q >> (W - 1)) & 1;
        if (en != 0) begin
            if (mode == 1) begin
                m_q = (m_q >> 1) | (sir << (W - 1)); shifted = 1'b1;
            end else if (mode == 2) begin
                m_q = ((m_q << 1) | sil) & mask; shifted = 1'b1;
            end else if (mode == 3) begin
                m_q = pin & mask; m_cnt = 0;
            end else if (mode == 4 && ROT) begin
                m_q = (m_q >> 1) | ((m_q & 1) << (W - 1)); shifted = 1'b1;
            end else if (mode == 5 && ROT) begin
                m_q = ((m_q << 1) | (m_q >> (W - 1))) & mask; shifted = 1'b1;
            end else if (mode == 6) begin
                m_q = 0; m_cnt = 0;
            end
        end
        m_wd = (shifted && m_cnt == W - 1) ? 1 : 0;
        if (shifted && m_cnt < W) m_cnt = m_cnt + 1;
    endtask

    task automatic drive(input int en, input int mode, input int sir, input int sil, input int pin);
        exp_t e;
        @(negedge clk);
        bus.en          = en[0];
        bus.mode        = mode[2:0];
        bus.serial_in_r = sir[0];
        bus.serial_in_l = sil[0];
        bus.par_in      = pin[W-1:0];
        model_step(en, mode, sir, sil, pin);
        e.q   = m_q[W-1:0];
        e.sr  = m_sr[0];
        e.sl  = m_sl[0];
        e.cnt = m_cnt[CW-1:0];
        e.wd  = m_wd[0];
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.mode = 3'b000;
        bus.serial_in_r = 1'b0; bus.serial_in_l = 1'b0; bus.par_in = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (bus.par_out !== '0 || bus.serial_out_r !== 1'b0 || bus.serial_out_l !== 1'b0 ||
            bus.shift_cnt !== '0 || bus.word_done !== 1'b0) begin
            bad++;
            $display("FAIL %s: got q=%b sr=%b sl=%b cnt=%0d wd=%b, want all zero", tag,
                     bus.par_out, bus.serial_out_r, bus.serial_out_l, bus.shift_cnt, bus.word_done);
        end
    endtask

    // monitor: one expected response per clock while stimulus is active
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {bus.par_out, bus.serial_out_r, bus.serial_out_l, bus.shift_cnt, bus.word_done};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL cycle_chk t=%0t: got q=%b sr=%b sl=%b cnt=%0d wd=%b want q=%b sr=%b sl=%b cnt=%0d wd=%b",
                             $time, got.q, got.sr, got.sl, got.cnt, got.wd, e.q, e.sr, e.sl, e.cnt, e.wd);
                end
            end
        end
    end

    initial begin
        model_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // load A then asynchronous reset mid-cycle
        drive(1, 3, 0, 0, 'hA);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        reset = 1'b1;

        // load 1011, shift right four times with zero fill
        drive(1, 3, 0, 0, 'b1011);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // clear, shift left 1,0,0,1, then saturated shifts
        drive(1, 6, 0, 0, 0);
        drive(1, 2, 0, 1, 0);
        drive(1, 2, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        drive(1, 2, 0, 1, 0);
        drive(1, 2, 0, 1, 0);
        drive(1, 2, 0, 0, 0);

        // rotate right (hold when the rotate feature is absent)
        drive(1, 3, 0, 0, 'b0001);
        for (int i = 0; i < 4; i++) drive(1, 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 5, 0, 0, 0);

        // enable low and reserved mode
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 7, 1, 1, 0);

        // load and clear at cnt=3: no pulse
        drive(1, 3, 0, 0, 'h5);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0);
        drive(1, 3, 0, 0, 'hF);
        for (int i = 0; i < 3; i++) drive(1, 2, 0, 1, 0);
        drive(1, 6, 0, 0, 0);

        // load directly after word_done restarts the frame
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0);
        drive(1, 3, 0, 0, 'h6);
        for (int i = 0; i < 4; i++) drive(1, 2, 0, 1, 0);

        // random mix, biased toward shifts so the counter saturates often
        for (int i = 0; i < 600; i++) begin
            int r, md;
            r = $urandom_range(0, 15);
            md = (r < 5) ? 1 : (r < 10) ? 2 : (r < 12) ? $urandom_range(3, 7) : $urandom_range(0, 7);
            drive(($urandom_range(0, 7) != 0) ? 1 : 0, md, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, mask));
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
